biriscv_bpred: RTL and testbench



---
 rtl/biriscv_bpred_pkg.sv | 15 +
 rtl/biriscv_bpred_ras.sv | 45 ++++
 rtl/biriscv_bpred.sv | 135 +++++++++++++
 tb/tb_biriscv_bpred.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_bpred_pkg.sv
// rtl/biriscv_bpred_pkg.sv - shared branch-type encoding and default predictor sizes
package biriscv_bpred_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_CALL = 2'd1,
    BR_RET  = 2'd2,
    BR_JMP  = 2'd3
  } br_type_t;

  localparam int BPRED_BTB_ENTRIES = 8;
  localparam int BPRED_BHT_ENTRIES = 32;
  localparam int BPRED_RAS_DEPTH   = 8;

endpackage

// File: rtl/biriscv_bpred_ras.sv
// rtl/biriscv_bpred_ras.sv - circular return address stack; a push when full drops the oldest entry
module biriscv_bpred_ras
  import biriscv_bpred_pkg::*;
#(
  parameter int DEPTH = BPRED_RAS_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] push_data_i,
  output logic [31:0] top_o,
  output logic        empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  logic [31:0]   stack [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0]   count;

  // ptr is the next write slot, so the top lives one below it
  assign top_o   = stack[ptr - PTR_ONE];
  assign empty_o = (count == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr   <= '0;
      count <= '0;
    end else if (push_i) begin
      ptr <= ptr + PTR_ONE;
      if (count != CNT_MAX) count <= count + 1'b1;
    end else if (pop_i && count != '0) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_i) stack[ptr] <= push_data_i;
  end

endmodule

// File: rtl/biriscv_bpred.sv
// rtl/biriscv_bpred.sv - fetch-side predictor: fully associative BTB, 2-bit BHT and RAS
module biriscv_bpred
  import biriscv_bpred_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = BPRED_BTB_ENTRIES,
  parameter int NUM_BHT_ENTRIES = BPRED_BHT_ENTRIES,
  parameter int RAS_DEPTH       = BPRED_RAS_DEPTH,
  parameter int ENABLE          = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_f_i,
  input  logic        branch_request_i,
  input  logic        branch_is_taken_i,
  input  logic        branch_is_not_taken_i,
  input  logic [31:0] branch_source_i,
  input  logic [31:0] branch_pc_i,
  input  logic        branch_is_call_i,
  input  logic        branch_is_ret_i,
  input  logic        branch_is_jmp_i,
  output logic [31:0] next_pc_f_o,
  output logic        next_taken_f_o
);

  localparam int BTB_W = $clog2(NUM_BTB_ENTRIES);
  localparam int BHT_W = $clog2(NUM_BHT_ENTRIES);

  logic             btb_valid  [NUM_BTB_ENTRIES];
  logic [31:0]      btb_tag    [NUM_BTB_ENTRIES];
  logic [31:0]      btb_target [NUM_BTB_ENTRIES];
  br_type_t         btb_type   [NUM_BTB_ENTRIES];
  logic [BTB_W-1:0] btb_ptr;
  logic [1:0]       bht        [NUM_BHT_ENTRIES];

  logic             lk_hit;
  logic [BTB_W-1:0] lk_idx;
  logic             up_hit;
  logic [BTB_W-1:0] up_idx;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic [31:0]      ras_top;
  logic             ras_empty;
  br_type_t         up_type;
  logic [BHT_W-1:0] up_bht_idx;

  // Allocation happens only on a miss, so at most one tag can match either port
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    up_hit = 1'b0;
    up_idx = '0;
    for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
      if (btb_valid[i] && btb_tag[i] == pc_f_i) begin
        lk_hit = 1'b1;
        lk_idx = BTB_W'(i);
      end
      if (btb_valid[i] && btb_tag[i] == branch_source_i) begin
        up_hit = 1'b1;
        up_idx = BTB_W'(i);
      end
    end
  end

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = btb_target[lk_idx];
    if (lk_hit) begin
      case (btb_type[lk_idx])
        BR_RET: begin
          pred_taken = 1'b1;
          if (!ras_empty) pred_target = ras_top;
        end
        BR_CALL, BR_JMP: pred_taken = 1'b1;
        default: pred_taken = bht[pc_f_i[BHT_W+1:2]][1];
      endcase
    end
  end

  assign next_taken_f_o = (ENABLE != 0) && pred_taken;
  assign next_pc_f_o    = next_taken_f_o ? pred_target : pc_f_i + 32'd4;

  assign up_type = branch_is_call_i ? BR_CALL :
                   branch_is_ret_i  ? BR_RET  :
                   branch_is_jmp_i  ? BR_JMP  : BR_COND;
  assign up_bht_idx = branch_source_i[BHT_W+1:2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
      btb_ptr <= '0;
    end else if (branch_request_i && !up_hit && branch_is_taken_i) begin
      btb_valid[btb_ptr] <= 1'b1;
      btb_ptr            <= btb_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && branch_request_i) begin
      if (up_hit) begin
        btb_type[up_idx] <= up_type;
        if (branch_is_taken_i) btb_target[up_idx] <= branch_pc_i;
      end else if (branch_is_taken_i) begin
        btb_tag[btb_ptr]    <= branch_source_i;
        btb_target[btb_ptr] <= branch_pc_i;
        btb_type[btb_ptr]   <= up_type;
      end
    end
  end

  // Taken wins when both resolution flags are raised
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (branch_request_i && up_type == BR_COND) begin
      if (branch_is_taken_i) begin
        if (bht[up_bht_idx] != 2'b11) bht[up_bht_idx] <= bht[up_bht_idx] + 2'b01;
      end else if (branch_is_not_taken_i) begin
        if (bht[up_bht_idx] != 2'b00) bht[up_bht_idx] <= bht[up_bht_idx] - 2'b01;
      end
    end
  end

  biriscv_bpred_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (branch_request_i && branch_is_call_i),
    .pop_i      (branch_request_i && branch_is_ret_i && !branch_is_call_i),
    .push_data_i(branch_source_i + 32'd4),
    .top_o      (ras_top),
    .empty_o    (ras_empty)
  );

endmodule

// File: tb/tb_biriscv_bpred.sv
// tb/tb_biriscv_bpred.sv - scoreboard bench for biriscv_bpred against a queue/map reference model
module tb_biriscv_bpred;

  localparam int NBTB = 8;
  localparam int NBHT = 32;
  localparam int NRAS = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_f_i = '0;
  logic        branch_request_i = 1'b0;
  logic        branch_is_taken_i = 1'b0;
  logic        branch_is_not_taken_i = 1'b0;
  logic [31:0] branch_source_i = '0;
  logic [31:0] branch_pc_i = '0;
  logic        branch_is_call_i = 1'b0;
  logic        branch_is_ret_i = 1'b0;
  logic        branch_is_jmp_i = 1'b0;
  logic [31:0] next_pc_f_o;
  logic        next_taken_f_o;

  biriscv_bpred #(
    .NUM_BTB_ENTRIES(NBTB),
    .NUM_BHT_ENTRIES(NBHT),
    .RAS_DEPTH(NRAS),
    .ENABLE(1)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .pc_f_i               (pc_f_i),
    .branch_request_i     (branch_request_i),
    .branch_is_taken_i    (branch_is_taken_i),
    .branch_is_not_taken_i(branch_is_not_taken_i),
    .branch_source_i      (branch_source_i),
    .branch_pc_i          (branch_pc_i),
    .branch_is_call_i     (branch_is_call_i),
    .branch_is_ret_i      (branch_is_ret_i),
    .branch_is_jmp_i      (branch_is_jmp_i),
    .next_pc_f_o          (next_pc_f_o),
    .next_taken_f_o       (next_taken_f_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: BTB as a map with FIFO eviction, RAS as a bounded queue
  typedef struct {
    logic [31:0] target;
    int          ty;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [32:0] exp;
  } chk_t;

  ent_t        m_btb [logic [31:0]];
  logic [31:0] m_fifo [$];
  logic [31:0] m_ras [$];
  int          m_bht [NBHT];
  chk_t        exp_q [$];

  int   total = 0;
  int   bad = 0;
  logic look_valid = 1'b0;

  function automatic void model_reset();
    m_btb.delete();
    m_fifo.delete();
    m_ras.delete();
    for (int i = 0; i < NBHT; i++) m_bht[i] = 1;
  endfunction

  function automatic logic [32:0] model_predict(logic [31:0] pc);
    ent_t e;
    logic tk;
    logic [31:0] tgt;
    if (!m_btb.exists(pc)) return {1'b0, pc + 32'd4};
    e   = m_btb[pc];
    tgt = e.target;
    if (e.ty == 2) begin
      tk = 1'b1;
      if (m_ras.size() > 0) tgt = m_ras[m_ras.size()-1];
    end else if (e.ty == 1 || e.ty == 3) begin
      tk = 1'b1;
    end else begin
      tk = (m_bht[(pc >> 2) % NBHT] >= 2);
    end
    return tk ? {1'b1, tgt} : {1'b0, pc + 32'd4};
  endfunction

  function automatic void model_update(logic tk, logic ntk, logic [31:0] src, logic [31:0] tgt,
                                       logic call, logic ret, logic jmp);
    int   ty;
    int   k;
    ent_t e;
    ty = call ? 1 : ret ? 2 : jmp ? 3 : 0;
    if (m_btb.exists(src)) begin
      e    = m_btb[src];
      e.ty = ty;
      if (tk) e.target = tgt;
      m_btb[src] = e;
    end else if (tk) begin
      if (m_fifo.size() == NBTB) m_btb.delete(m_fifo.pop_front());
      e.target   = tgt;
      e.ty       = ty;
      m_btb[src] = e;
      m_fifo.push_back(src);
    end
    if (ty == 0) begin
      k = int'((src >> 2) % NBHT);
      if (tk) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
      else if (ntk) m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
    end
    if (call) begin
      m_ras.push_back(src + 32'd4);
      if (m_ras.size() > NRAS) void'(m_ras.pop_front());
    end else if (ret && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endfunction

  task automatic step(input logic [31:0] pc, input logic req, input logic tk, input logic ntk,
                      input logic [31:0] src, input logic [31:0] tgt,
                      input logic call, input logic ret, input logic jmp);
    chk_t c;
    @(posedge clk_i);
    #1;
    rst_i                 = 1'b0;
    pc_f_i                = pc;
    branch_request_i      = req;
    branch_is_taken_i     = tk;
    branch_is_not_taken_i = ntk;
    branch_source_i       = src;
    branch_pc_i           = tgt;
    branch_is_call_i      = call;
    branch_is_ret_i       = ret;
    branch_is_jmp_i       = jmp;
    look_valid            = 1'b1;
    c.pc  = pc;
    c.exp = model_predict(pc);
    exp_q.push_back(c);
    if (req) model_update(tk, ntk, src, tgt, call, ret, jmp);
  endtask

  // Lookup only; branch side-band inputs carry noise that must be ignored
  task automatic look(input logic [31:0] pc);
    step(pc, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom,
         1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i);
      #1;
      rst_i             = 1'b1;
      look_valid        = 1'b0;
      branch_request_i  = 1'b1;
      branch_is_taken_i = 1'b1;
      branch_is_jmp_i   = 1'b1;
      branch_source_i   = 32'h8000_0000;
      branch_pc_i       = 32'h9000_0000;
    end
    model_reset();
  endtask

  initial begin : monitor
    chk_t c;
    forever begin
      @(negedge clk_i);
      if (look_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL no_expected_entry pc=%h got taken=%0d next=%h", pc_f_i, next_taken_f_o, next_pc_f_o);
        end else begin
          c = exp_q.pop_front();
          if ({next_taken_f_o, next_pc_f_o} !== c.exp) begin
            bad++;
            $display("FAIL predict pc=%h got taken=%0d next=%h want taken=%0d next=%h",
                     c.pc, next_taken_f_o, next_pc_f_o, c.exp[32], c.exp[31:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : driver
    logic [31:0] src;
    logic [31:0] pc;
    logic [2:0]  kind;
    logic        tk;
    logic        ntk;
    int          waited;

    do_reset();
    look(32'h8000_0000);

    step(32'h100, 1, 1, 0, 32'h100, 32'h200, 0, 0, 0);
    look(32'h100);
    step(32'h0,   1, 0, 1, 32'h100, 32'h104, 0, 0, 0);
    step(32'h0,   1, 0, 1, 32'h100, 32'h104, 0, 0, 0);
    look(32'h100);

    step(32'h300,  1, 1, 0, 32'h300,  32'h1000, 1, 0, 0);
    step(32'h1010, 1, 1, 0, 32'h1010, 32'h304,  0, 1, 0);
    step(32'h300,  1, 1, 0, 32'h300,  32'h1000, 1, 0, 0);
    look(32'h1010);

    for (int i = 0; i < 9; i++)
      step(32'h10 + 32'(4*i), 1, 1, 0, 32'h10 + 32'(4*i), 32'h3000 + 32'(16*i), 0, 0, 1);
    look(32'h10);
    look(32'h30);

    for (int i = 0; i < 9; i++)
      step(32'h400 + 32'(4*i), 1, 1, 0, 32'h400 + 32'(4*i), 32'h2000, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      step(32'h1010, 1, 1, 0, 32'h1010, 32'h7770, 0, 1, 0);
    look(32'h1010);

    step(32'h500, 1, 1, 0, 32'h500, 32'h600, 0, 0, 1);
    look(32'h500);

    step(32'h704, 1, 1, 1, 32'h704, 32'h800, 0, 0, 0);
    look(32'h704);
    step(32'h0, 1, 1, 0, 32'h704, 32'h800, 0, 0, 0);
    look(32'h704);

    step(32'h600, 1, 1, 0, 32'h600, 32'h900, 1, 1, 0);
    look(32'h600);

    for (int n = 0; n < 500; n++) begin
      src  = 32'h100 + 32'(4 * $urandom_range(0, 15));
      pc   = 32'h100 + 32'(4 * $urandom_range(0, 15));
      kind = 3'($urandom_range(0, 6));
      tk   = 1'($urandom);
      ntk  = 1'($urandom);
      step(pc, 1'($urandom_range(0, 3) != 0), tk, ntk, src,
           tk ? ($urandom & 32'hffff_fffc) : src + 32'd4,
           kind == 3'd1, kind == 3'd2 || (kind == 3'd6 && tk), kind == 3'd3);
    end

    if ($urandom_range(0, 1) == 0) do_reset(); else begin
      do_reset();
    end
    look(32'h100);
    look(32'h1010);

    @(posedge clk_i);
    #1;
    look_valid = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk_i);
      waited++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
